// File: rtl/naive2_to_sramlike_arb_pkg.sv
// rtl/naive2_to_sramlike_arb_pkg.sv - shared encodings for the two-port naive to SRAM-like bridge
package naive2_to_sramlike_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Bit positions inside the two-bit request/grant vectors.
    localparam int REQ_I = 0;
    localparam int REQ_D = 1;

endpackage

// File: rtl/naive2_to_sramlike_arb_arb.sv
// rtl/naive2_to_sramlike_arb_arb.sv - two-requester arbiter (naive_arb2) with round-robin pointer
module naive_arb2
    import naive2_to_sramlike_arb_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic [1:0] served,
    input  logic       mode,
    output logic [1:0] grant
);

    // ptr_d = 1 means the data port wins a tie in round-robin mode.
    logic ptr_d;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr_d <= 1'b1;
        end else if (advance && mode) begin
            ptr_d <= served[REQ_I];
        end
    end

    always_comb begin
        grant = 2'b00;
        if (req[REQ_D] && (!req[REQ_I] || !mode || ptr_d)) begin
            grant[REQ_D] = 1'b1;
        end else if (req[REQ_I]) begin
            grant[REQ_I] = 1'b1;
        end
    end

endmodule

// File: rtl/naive2_to_sramlike_arb.sv
// rtl/naive2_to_sramlike_arb.sv - bridges instruction and data naive ports onto one SRAM-like master
module naive2_to_sramlike_arb
    import naive2_to_sramlike_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ARB_MODE = 0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                i_en,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_stall,
    input  logic                d_en,
    input  logic                d_wr,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W/8-1:0] d_ben,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_stall,
    output logic                m_req,
    output logic                m_wr,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W/8-1:0] m_ben,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_addr_ok,
    input  logic                m_data_ok,
    input  logic [DATA_W-1:0]   m_rdata
);

    localparam int BEN_W = DATA_W / 8;

    state_t              state;
    state_t              state_nx;
    owner_t              owner;
    logic                req_wr;
    logic [ADDR_W-1:0]   req_addr;
    logic [BEN_W-1:0]    req_ben;
    logic [DATA_W-1:0]   req_wdata;
    logic                live;
    logic [1:0]          grant;
    logic                complete;
    logic                owner_en;

    assign owner_en = (owner == OWN_I) ? i_en :
                      (owner == OWN_D) ? d_en : 1'b0;

    assign complete = ((state == ST_ADDR) && m_addr_ok && m_data_ok) ||
                      ((state == ST_DATA) && m_data_ok);

    assign i_stall = i_en && !((owner == OWN_I) && complete);
    assign d_stall = d_en && !((owner == OWN_D) && complete);

    naive_arb2 u_arb (
        .clk     (clk),
        .resetn  (resetn),
        .req     ({d_en, i_en}),
        .advance (complete),
        .served  ({owner == OWN_D, owner == OWN_I}),
        .mode    (ARB_MODE == ARB_RR),
        .grant   (grant)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (|grant) state_nx = ST_ADDR;
            ST_ADDR: if (m_addr_ok) state_nx = m_data_ok ? ST_IDLE : ST_DATA;
            ST_DATA: if (m_data_ok) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        m_req   = (state == ST_ADDR);
        m_wr    = 1'b0;
        m_addr  = '0;
        m_ben   = '0;
        m_wdata = '0;
        if (m_req) begin
            m_wr    = req_wr;
            m_addr  = req_addr;
            m_ben   = req_ben;
            m_wdata = req_wdata;
        end
    end

    // live drops for good once the owner lets go of its enable, so a withdrawn
    // read never lands in the rdata register even if the enable comes back.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            owner     <= OWN_NONE;
            req_wr    <= 1'b0;
            req_addr  <= '0;
            req_ben   <= '0;
            req_wdata <= '0;
            live      <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else if (state == ST_IDLE) begin
            if (grant[REQ_D]) begin
                owner     <= OWN_D;
                req_wr    <= d_wr;
                req_addr  <= d_addr;
                req_ben   <= d_wr ? d_ben : {BEN_W{1'b1}};
                req_wdata <= d_wdata;
                live      <= 1'b1;
            end else if (grant[REQ_I]) begin
                owner     <= OWN_I;
                req_wr    <= 1'b0;
                req_addr  <= i_addr;
                req_ben   <= {BEN_W{1'b1}};
                req_wdata <= '0;
                live      <= 1'b1;
            end
        end else begin
            if (!owner_en) begin
                live <= 1'b0;
            end
            if (complete) begin
                owner <= OWN_NONE;
                if (!req_wr && live && owner_en) begin
                    if (owner == OWN_I) begin
                        i_rdata <= m_rdata;
                    end else if (owner == OWN_D) begin
                        d_rdata <= m_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_naive2_to_sramlike_arb.sv
// tb/tb_naive2_to_sramlike_arb.sv - directed scoreboard bench for fixed and round-robin bridge instances
module tb_naive2_to_sramlike_arb;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_en, d_en, d_wr;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_ben;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;

    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic        i_stall, d_stall, m_req, m_wr;
    logic [3:0]  m_ben;

    logic [31:0] i_rdata_1, d_rdata_1, m_addr_1, m_wdata_1;
    logic        i_stall_1, d_stall_1, m_req_1, m_wr_1;
    logic [3:0]  m_ben_1;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] d_last;

    always #5 clk = ~clk;

    naive2_to_sramlike_arb #(.ADDR_W(32), .DATA_W(32), .ARB_MODE(0)) dut0 (
        .clk(clk), .resetn(resetn),
        .i_en(i_en), .i_addr(i_addr), .i_rdata(i_rdata), .i_stall(i_stall),
        .d_en(d_en), .d_wr(d_wr), .d_addr(d_addr), .d_ben(d_ben), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_stall(d_stall),
        .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_ben(m_ben), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    naive2_to_sramlike_arb #(.ADDR_W(32), .DATA_W(32), .ARB_MODE(1)) dut1 (
        .clk(clk), .resetn(resetn),
        .i_en(i_en), .i_addr(i_addr), .i_rdata(i_rdata_1), .i_stall(i_stall_1),
        .d_en(d_en), .d_wr(d_wr), .d_addr(d_addr), .d_ben(d_ben), .d_wdata(d_wdata),
        .d_rdata(d_rdata_1), .d_stall(d_stall_1),
        .m_req(m_req_1), .m_wr(m_wr_1), .m_addr(m_addr_1), .m_ben(m_ben_1), .m_wdata(m_wdata_1),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_pop(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            chk(tag, obs, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; i_en = 1'b0; d_en = 1'b0; d_wr = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; d_ben = '0;
        m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = '0;
        d_last = '0;
        repeat (3) tick();

        chk1("rst_m_req", m_req, 1'b0);
        chk1("rst_m_wr", m_wr, 1'b0);
        chk("rst_m_addr", m_addr, 32'h0);
        chk("rst_m_ben", 32'(m_ben), 32'h0);
        chk("rst_m_wdata", m_wdata, 32'h0);
        chk("rst_i_rdata", i_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        d_en = 1'b1; #1;
        chk1("rst_d_stall_en", d_stall, 1'b1);
        d_en = 1'b0; #1;
        chk1("rst_d_stall_idle", d_stall, 1'b0);

        resetn = 1'b1;
        tick();
        m_data_ok = 1'b1; m_rdata = 32'hbad0bad0;
        tick();
        m_data_ok = 1'b0;
        chk("idle_dok_i_rdata", i_rdata, 32'h0);
        chk("idle_dok_d_rdata", d_rdata, 32'h0);
        chk1("idle_dok_m_req", m_req, 1'b0);

        // Instruction-only read: addr_ok in cycle 2, data_ok in cycle 4.
        i_en = 1'b1; i_addr = 32'h1fc00000;
        tick();
        chk1("t1_c1_m_req", m_req, 1'b1);
        chk("t1_c1_m_addr", m_addr, 32'h1fc00000);
        chk("t1_c1_m_ben", 32'(m_ben), 32'hf);
        chk1("t1_c1_m_wr", m_wr, 1'b0);
        tick();
        chk1("t1_c2_m_req", m_req, 1'b1);
        m_addr_ok = 1'b1;
        tick();
        m_addr_ok = 1'b0;
        chk1("t1_c3_m_req", m_req, 1'b0);
        chk1("t1_c3_i_stall", i_stall, 1'b1);
        tick();
        m_data_ok = 1'b1; m_rdata = 32'h3c1d0001;
        exp_q.push_back(32'h3c1d0001);
        #1 chk1("t1_c4_i_stall", i_stall, 1'b0);
        tick();
        m_data_ok = 1'b0; i_en = 1'b0;
        chk_pop("t1_c5_i_rdata", i_rdata);
        chk1("t1_c5_m_req", m_req, 1'b0);

        // Both ports request continuously: fixed instance stays on D, round-robin alternates.
        i_en = 1'b1; i_addr = 32'h00001000;
        d_en = 1'b1; d_wr = 1'b0; d_addr = 32'h00002000;
        exp_q.push_back(32'h00002000);
        exp_q.push_back(32'h00001000);
        exp_q.push_back(32'h00002000);
        exp_q.push_back(32'h00001000);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t3_fixed_grant", m_addr, 32'h00002000);
            chk_pop("t3_rr_grant", m_addr_1);
            chk1("t3_fixed_i_stall", i_stall, 1'b1);
            m_addr_ok = 1'b1;
            tick();
            m_addr_ok = 1'b0;
            m_data_ok = 1'b1;
            m_rdata = 32'h00005000 + 32'(k);
            d_last = m_rdata;
            #1;
            chk1("t3_nonowner_i_stall", i_stall, 1'b1);
            chk1("t3_owner_d_stall", d_stall, 1'b0);
            tick();
            m_data_ok = 1'b0;
            chk("t3_d_rdata", d_rdata, d_last);
        end
        i_en = 1'b0; d_en = 1'b0;

        // Data write held through three cycles without addr_ok.
        d_en = 1'b1; d_wr = 1'b1; d_addr = 32'h80000010; d_ben = 4'b0011; d_wdata = 32'hdeadbeef;
        tick();
        d_addr = 32'h0; d_wdata = 32'h0; d_ben = 4'hf;
        for (int k = 0; k < 3; k++) begin
            chk1("t2_m_req", m_req, 1'b1);
            chk1("t2_m_wr", m_wr, 1'b1);
            chk("t2_m_addr", m_addr, 32'h80000010);
            chk("t2_m_ben", 32'(m_ben), 32'h3);
            chk("t2_m_wdata", m_wdata, 32'hdeadbeef);
            tick();
        end
        m_addr_ok = 1'b1;
        tick();
        m_addr_ok = 1'b0;
        chk1("t2_data_m_req", m_req, 1'b0);
        chk("t2_data_m_ben", 32'(m_ben), 32'h0);
        m_data_ok = 1'b1; m_rdata = 32'hffffffff;
        #1 chk1("t2_d_stall", d_stall, 1'b0);
        tick();
        m_data_ok = 1'b0; d_en = 1'b0; d_wr = 1'b0;
        chk("t2_d_rdata_kept", d_rdata, d_last);

        // addr_ok and data_ok together: 2-cycle transactions back to back.
        i_en = 1'b1; i_addr = 32'h1fc00040;
        tick();
        chk1("t4_m_req", m_req, 1'b1);
        m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'ha5a50004;
        exp_q.push_back(32'ha5a50004);
        #1 chk1("t4_i_stall", i_stall, 1'b0);
        tick();
        m_addr_ok = 1'b0; m_data_ok = 1'b0; i_addr = 32'h1fc00044;
        chk1("t4_idle_m_req", m_req, 1'b0);
        chk_pop("t4_i_rdata", i_rdata);
        tick();
        chk1("t4_regrant_m_req", m_req, 1'b1);
        chk("t4_regrant_m_addr", m_addr, 32'h1fc00044);
        m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'ha5a50008;
        exp_q.push_back(32'ha5a50008);
        tick();
        m_addr_ok = 1'b0; m_data_ok = 1'b0; i_en = 1'b0;
        chk_pop("t4_i_rdata2", i_rdata);

        // Data read withdrawn during DATA; instruction waits for IDLE.
        d_en = 1'b1; d_wr = 1'b0; d_addr = 32'h80000100;
        tick();
        chk("t5_m_addr", m_addr, 32'h80000100);
        m_addr_ok = 1'b1;
        tick();
        m_addr_ok = 1'b0;
        d_en = 1'b0; i_en = 1'b1; i_addr = 32'h1fc00080;
        #1;
        chk1("t5_d_stall", d_stall, 1'b0);
        chk1("t5_i_stall", i_stall, 1'b1);
        tick();
        chk1("t5_data_m_req", m_req, 1'b0);
        m_data_ok = 1'b1; m_rdata = 32'h12345678;
        #1 chk1("t5_i_stall_dok", i_stall, 1'b1);
        tick();
        m_data_ok = 1'b0;
        chk("t5_d_rdata_kept", d_rdata, d_last);
        chk1("t5_idle_m_req", m_req, 1'b0);
        tick();
        chk1("t5_i_grant_m_req", m_req, 1'b1);
        chk("t5_i_grant_m_addr", m_addr, 32'h1fc00080);

        // Reset while in DATA abandons the transaction.
        m_addr_ok = 1'b1;
        tick();
        m_addr_ok = 1'b0;
        chk1("t6_data_m_req", m_req, 1'b0);
        resetn = 1'b0;
        tick();
        chk1("t6_rst_m_req", m_req, 1'b0);
        chk("t6_rst_i_rdata", i_rdata, 32'h0);
        chk("t6_rst_d_rdata", d_rdata, 32'h0);
        m_data_ok = 1'b1; m_rdata = 32'hcafef00d;
        #1 chk1("t6_owner_none_i_stall", i_stall, 1'b1);
        tick();
        chk("t6_rst_i_rdata_hold", i_rdata, 32'h0);
        resetn = 1'b1; m_data_ok = 1'b0; i_en = 1'b0;
        tick();
        chk1("t6_post_m_req", m_req, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
